// File: rtl/rr_dp_sequencer.sv
// rr_dp_sequencer: round-robin sharing of one fixed-latency increment datapath among NUM_REQ requesters
// ports: req_valid/req_data/req_ready accept one operand; dp_valid/dp_data/dp_result drive the datapath;
// rsp_valid/rsp_data/rsp_ready return the result; grant_id, busy and sticky err_mismatch report status
module rr_dp_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int DP_LATENCY = 1,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dp_valid,
  output logic [DATA_W-1:0]         dp_data,
  input  logic [DATA_W-1:0]         dp_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [IW-1:0]             grant_id,
  output logic                      busy,
  output logic                      err_mismatch
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, win, idx;
  logic [DATA_W-1:0] op_q, op_d, dpd_q, dpd_d, rspd_q, rspd_d;
  logic [NUM_REQ-1:0] rspv_q, rspv_d;
  logic [2:0] cnt_q, cnt_d;
  logic dpv_q, dpv_d, err_q, err_d, hit;
  // descending scan so the last hit kept is the nearest requester after ptr_q
  always_comb begin
    win = ptr_q;
    hit = 1'b0;
    idx = ptr_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    op_d = op_q;
    dpv_d = 1'b0;
    dpd_d = dpd_q;
    cnt_d = cnt_q;
    rspv_d = rspv_q;
    rspd_d = rspd_q;
    err_d = err_q;
    req_ready = (state_q == IDLE && hit && !reset) ? NUM_REQ'(1) << win : '0;
    case (state_q)
      IDLE: if (hit) begin
        op_d = req_data[win*DATA_W +: DATA_W];
        grant_d = win;
        ptr_d = win;
        state_d = ISSUE;
      end
      ISSUE: begin
        dpv_d = 1'b1;
        dpd_d = op_q;
        cnt_d = 3'(DP_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rspd_d = dp_result;
          rspv_d = NUM_REQ'(1) << grant_q;
          err_d = err_q | (dp_result != op_q + DATA_W'(1));
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready[grant_q]) begin
        rspv_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      op_q <= '0;
      dpv_q <= 1'b0;
      dpd_q <= '0;
      cnt_q <= '0;
      rspv_q <= '0;
      rspd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      op_q <= op_d;
      dpv_q <= dpv_d;
      dpd_q <= dpd_d;
      cnt_q <= cnt_d;
      rspv_q <= rspv_d;
      rspd_q <= rspd_d;
      err_q <= err_d;
    end
  end
  assign dp_valid = dpv_q;
  assign dp_data = dpd_q;
  assign rsp_valid = rspv_q;
  assign rsp_data = rspd_q;
  assign grant_id = grant_q;
  assign busy = state_q != IDLE;
  assign err_mismatch = err_q;
endmodule

// File: tb/tb_rr_dp_sequencer.sv
// tb_rr_dp_sequencer: transaction-level model check of rr_dp_sequencer at latencies 1 and 3
module tb_rr_dp_sequencer;
  localparam int N = 4, W = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction
  function automatic logic [W-1:0] bad(input logic [W-1:0] op);
    return op == 8'h10 ? 8'h55 : W'(op + 1) ^ 8'h5A;
  endfunction
  for (genvar l = 0; l < 2; l++) begin : ln
    localparam int L = (l == 0) ? 1 : 3;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0, rsp_ready = '1, req_ready, rsp_valid;
    logic [N*W-1:0] req_data = '0;
    logic [W-1:0] dp_data, dp_result, rsp_data, noise = '0;
    logic [1:0] grant_id;
    logic dp_valid, busy, err_mismatch;
    bit live, done, fault_next;
    bit m_busy, m_rsp, m_err, m_fault;
    int m_t, m_g, m_gid, m_ptr, wc, k;
    logic [W-1:0] m_op, m_dpd, m_rd;
    int got [6];
    rr_dp_sequencer #(.NUM_REQ(N), .DATA_W(W), .DP_LATENCY(L)) dut (
      .clk(clk), .reset(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .dp_valid(dp_valid), .dp_data(dp_data), .dp_result(dp_result), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_ready(rsp_ready), .grant_id(grant_id), .busy(busy),
      .err_mismatch(err_mismatch));
    always_comb wc = winner(req_valid, m_ptr);
    // datapath stand-in: the true result appears only in the cycle the result must be sampled, noise elsewhere
    assign dp_result = (m_busy && !m_rsp && m_t == L) ? (m_fault ? bad(m_op) : W'(m_op + 1)) : noise;
    // m_t counts clock edges since the accept edge of the current transaction
    always @(posedge clk) begin
      noise <= W'($urandom);
      if (rst) begin
        m_busy <= 0; m_rsp <= 0; m_err <= 0; m_ptr <= N - 1; m_gid <= 0;
        m_dpd <= '0; m_rd <= '0; m_t <= 0; live <= 1;
      end else if (!m_busy) begin
        if (wc >= 0) begin
          m_busy <= 1; m_t <= 0; m_g <= wc; m_gid <= wc; m_ptr <= wc;
          m_op <= req_data[wc*W +: W]; m_fault <= fault_next;
        end
      end else if (m_rsp) begin
        if (rsp_ready[m_g]) begin
          m_rsp <= 0; m_busy <= 0;
        end
      end else begin
        m_t <= m_t + 1;
        if (m_t == 0) m_dpd <= m_op;
        if (m_t == L) begin
          m_rsp <= 1;
          m_rd <= m_fault ? bad(m_op) : W'(m_op + 1);
          m_err <= m_err | m_fault;
        end
      end
    end
    always @(negedge clk) if (live) begin
      chk($sformatf("L%0d req_ready", L), req_ready, (!rst && !m_busy && wc >= 0) ? 1 << wc : 0);
      chk($sformatf("L%0d dp_valid", L), dp_valid, m_busy && !m_rsp && m_t == 1);
      chk($sformatf("L%0d dp_data", L), dp_data, m_dpd);
      chk($sformatf("L%0d rsp_valid", L), rsp_valid, m_rsp ? 1 << m_g : 0);
      chk($sformatf("L%0d rsp_data", L), rsp_data, m_rd);
      chk($sformatf("L%0d grant_id", L), grant_id, m_gid);
      chk($sformatf("L%0d busy", L), busy, m_busy);
      chk($sformatf("L%0d err", L), err_mismatch, m_err);
    end
    task automatic pulse_rst();
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
    endtask
    task automatic acc(input int r, input logic [W-1:0] d);
      int c = 0;
      @(posedge clk); #1;
      req_valid = N'(1 << r);
      req_data[r*W +: W] = d;
      @(negedge clk);
      while (req_ready == 0 && c < 50) begin c++; @(negedge clk); end
      chk("accept", req_ready, 1 << r);
      @(posedge clk); #1 req_valid = '0;
    endtask
    task automatic wait_rsp();
      int c = 0;
      @(negedge clk);
      while (rsp_valid == 0 && c < 50) begin c++; @(negedge clk); end
      chk("rsp_seen", rsp_valid != 0, 1);
    endtask
    initial begin
      pulse_rst();
      @(posedge clk); #1 req_valid = 4'b0001; req_data[7:0] = 8'h10;
      @(negedge clk); chk("t1_ready", req_ready, 1); chk("t1_idle", busy, 0);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk); chk("t1_busy", busy, 1); chk("t1_dv_early", dp_valid, 0);
      @(negedge clk); chk("t1_dv", dp_valid, 1); chk("t1_dd", dp_data, 8'h10);
      repeat (L - 1) @(negedge clk);
      chk("t1_rv_early", rsp_valid, 0);
      @(negedge clk);
      chk("t1_rv", rsp_valid, 1); chk("t1_rd", rsp_data, 8'h11);
      chk("t1_gid", grant_id, 0); chk("t1_err", err_mismatch, 0);
      pulse_rst();
      for (int i = 0; i < 6; i++) got[i] = -1;
      @(posedge clk); #1 req_valid = '1;
      k = 0;
      for (int c = 0; c < 200 && k < 6; c++) begin
        @(negedge clk);
        if (req_ready != 0) begin got[k] = oh2i(req_ready); k++; end
      end
      @(posedge clk); #1 req_valid = '0;
      chk("t2_grants", k, 6);
      for (int i = 0; i < 6; i++) chk("t2_order", got[i], i % 4);
      pulse_rst();
      acc(2, 8'h3C);
      req_valid = 4'b0001; req_data[7:0] = 8'h10; rsp_ready = 4'b1011;
      wait_rsp();
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        chk("t3_rv", rsp_valid, 4'b0100); chk("t3_rd", rsp_data, 8'h3D); chk("t3_rr", req_ready, 0);
      end
      @(posedge clk); #1 rsp_ready = '1;
      @(negedge clk); chk("t3_hold", rsp_valid, 4'b0100);
      @(negedge clk); chk("t3_next", req_ready, 1); chk("t3_rv_off", rsp_valid, 0);
      @(posedge clk); #1 req_valid = '0;
      pulse_rst();
      acc(1, 8'hFF); wait_rsp();
      chk("t4_wrap", rsp_data, 0); chk("t4_err0", err_mismatch, 0);
      fault_next = 1; acc(0, 8'h10); fault_next = 0; wait_rsp();
      chk("t4_bad", rsp_data, 8'h55); chk("t4_err1", err_mismatch, 1);
      acc(2, 8'h20); wait_rsp();
      chk("t4_good", rsp_data, 8'h21); chk("t4_sticky", err_mismatch, 1);
      pulse_rst();
      @(negedge clk); chk("t4_clr", err_mismatch, 0);
      acc(2, 8'h44);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("t5_busy", busy, 0); chk("t5_rv", rsp_valid, 0); chk("t5_gid", grant_id, 0);
      @(posedge clk); #1 req_valid = 4'b1001;
      @(negedge clk); chk("t5_win", req_ready, 1);
      @(posedge clk); #1 req_valid = '0;
      wait_rsp();
      pulse_rst();
      for (int c = 0; c < 1500; c++) begin
        @(posedge clk); #1;
        req_valid = N'($urandom_range(0, 3) == 0 ? 0 : $urandom);
        req_data = $urandom;
        rsp_ready = $urandom_range(0, 1) ? '1 : N'($urandom);
        fault_next = $urandom_range(0, 15) == 0;
        rst = $urandom_range(0, 199) == 0;
      end
      @(posedge clk); #1 rst = 0; req_valid = '0; rsp_ready = '1; fault_next = 0;
      repeat (12) @(posedge clk);
      done = 1;
    end
  end
  initial begin
    for (int c = 0; c < 50000 && !(ln[0].done && ln[1].done); c++) @(posedge clk);
    chk("finish_timeout", ln[0].done && ln[1].done, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
